// File: rtl/hdmi_packet_pkg.sv
// Shared types, slot timing constants and the serial BCH step used by the
// data island packet path.
//   header_t      : 24-bit packet header HB0..HB2
//   subpacket_t   : 56-bit subpacket payload
//   next_ecc      : one bit of the reflected serial BCH(64,56) LFSR
package hdmi_packet_pkg;

  typedef logic [23:0] header_t;
  typedef logic [55:0] subpacket_t;

  localparam int PACKET_CYCLES = 32;
  localparam int HDR_ECC_START = 24;
  localparam int SUB_ECC_START = 28;

  localparam header_t    NULL_HEADER      = '0;
  localparam logic [7:0] ECC_POLY_DEFAULT = 8'h83;

  // Shift right and fold the feedback mask in whenever the outgoing LSB
  // differs from the incoming data bit.
  function automatic logic [7:0] next_ecc(input logic [7:0] e, input logic b,
                                          input logic [7:0] poly);
    next_ecc = (e >> 1) ^ ((e[0] ^ b) ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/packet_fifo.sv
// Whole-packet FIFO. One entry holds {header, subpackets}. Level is a
// registered count, so full/empty change only on the clock edge.
// Ports:
//   clk_pixel, reset : clock, synchronous active-high reset (empties FIFO)
//   push, wr_data    : write one packet (caller guarantees !full)
//   pop              : drop the head (caller guarantees !empty)
//   rd_data          : head entry, stable until popped
//   level            : packets queued
//   full, empty      : derived from level
module packet_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 248
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/packet_stream_assembler.sv
// Buffers whole packets and streams them in back-to-back 32-cycle slots while
// data_island_period is high, appending serially computed BCH parity. A null
// packet (all zero) fills any slot that starts with the FIFO empty.
// Optional build macro: PACKET_ECC_INJECT_EN adds ecc_inject, which flips
// bit 0 of every emitted parity byte for a slot when high at slot_start.
// Ports:
//   clk_pixel, reset      : pixel clock, synchronous active-high reset
//   data_island_period    : slots advance while high
//   pkt_valid/pkt_ready   : packet handshake, ready = FIFO not full
//   pkt_header, pkt_sub   : packet contents
//   packet_data           : [0] header BCH bit, [k+1]/[k+1+N] even/odd bits of subpacket k
//   counter               : bit position in the slot
//   slot_start            : counter==0 while island active
//   null_slot             : current slot carries the null packet
//   slot_aborted          : pulse after the island drops mid-slot
//   fifo_level            : packets queued
module packet_stream_assembler
  import hdmi_packet_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 2,
  parameter int         NUM_SUBPACKETS = 4,
  parameter logic [7:0] ECC_POLY       = ECC_POLY_DEFAULT
) (
  input  logic                                clk_pixel,
  input  logic                                reset,
  input  logic                                data_island_period,
  input  logic                                pkt_valid,
  output logic                                pkt_ready,
  input  header_t                             pkt_header,
  input  logic [NUM_SUBPACKETS-1:0][55:0]     pkt_sub,
`ifdef PACKET_ECC_INJECT_EN
  input  logic                                ecc_inject,
`endif
  output logic [2*NUM_SUBPACKETS:0]           packet_data,
  output logic [4:0]                          counter,
  output logic                                slot_start,
  output logic                                null_slot,
  output logic                                slot_aborted,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);
  localparam int N  = NUM_SUBPACKETS;
  localparam int PW = 24 + 56 * N;

  logic                island;
  logic                push, pop, fifo_full, fifo_empty;
  logic [PW-1:0]       head;
  logic                null_q, cur_null;
  logic                inj_q, inj_now;
  logic                last_cyc;
  header_t             cur_hdr;
  logic [N-1:0][55:0]  cur_sub;
  logic [7:0]          hdr_ecc;
  logic [31:0]         hdr_bch;

  assign island = data_island_period;

`ifdef PACKET_ECC_INJECT_EN
  assign inj_now = ecc_inject;
`else
  assign inj_now = 1'b0;
`endif

  packet_fifo #(.DEPTH(FIFO_DEPTH), .W(PW)) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .push      (push),
    .wr_data   ({pkt_header, pkt_sub}),
    .pop       (pop),
    .rd_data   (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pkt_ready = !fifo_full;
  assign push      = pkt_valid && pkt_ready;
  assign last_cyc  = (counter == 5'(PACKET_CYCLES - 1));

  // Slot source is decided at counter 0 from the live FIFO state and held in
  // null_q for the rest of the slot, so a push into an empty FIFO mid-slot
  // cannot leak into a null slot.
  assign cur_null   = (counter == '0) ? fifo_empty : null_q;
  assign slot_start = island && (counter == '0);
  assign null_slot  = island && cur_null;

  // The head is not popped until the last cycle, so it is read in place.
  assign pop     = island && last_cyc && !null_q;
  assign cur_hdr = cur_null ? NULL_HEADER : head[PW-1 -: 24];
  assign cur_sub = cur_null ? '0 : head[56*N-1:0];

  // Slot control. Dropping the island anywhere but after the last cycle
  // leaves counter nonzero, which is the abort condition.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter      <= '0;
      null_q       <= 1'b0;
      inj_q        <= 1'b0;
      slot_aborted <= 1'b0;
    end else begin
      slot_aborted <= !island && (counter != '0);
      if (island) begin
        counter <= counter + 5'd1;
        if (counter == '0) begin
          null_q <= fifo_empty;
          inj_q  <= inj_now;
        end
      end else begin
        counter <= '0;
      end
    end
  end

  // Header lane: 24 data bits then 8 parity bits, one per cycle. The parity
  // register is complete exactly when counter reaches 24.
  assign hdr_bch = {hdr_ecc ^ {7'b0, inj_q}, cur_hdr};

  always_ff @(posedge clk_pixel) begin
    if (reset || !island || last_cyc)
      hdr_ecc <= '0;
    else if (counter < 5'(HDR_ECC_START))
      hdr_ecc <= next_ecc(hdr_ecc, hdr_bch[counter], ECC_POLY);
  end

  assign packet_data[0] = island & hdr_bch[counter];

  // Subpacket lanes: two bits per cycle, 56 data bits then 8 parity bits.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [7:0]  ecc;
    logic [63:0] bch;
    logic [5:0]  bi_even, bi_odd;

    assign bi_even = {counter, 1'b0};
    assign bi_odd  = {counter, 1'b1};
    assign bch     = {ecc ^ {7'b0, inj_q}, cur_sub[k]};

    always_ff @(posedge clk_pixel) begin
      if (reset || !island || last_cyc)
        ecc <= '0;
      else if (counter < 5'(SUB_ECC_START))
        ecc <= next_ecc(next_ecc(ecc, bch[bi_even], ECC_POLY), bch[bi_odd], ECC_POLY);
    end

    assign packet_data[k+1]   = island & bch[bi_even];
    assign packet_data[k+1+N] = island & bch[bi_odd];
  end

endmodule

// File: tb/tb_packet_stream_assembler.sv
`timescale 1ns/1ps
module tb_packet_stream_assembler;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int PW    = 2 * N + 1;

  typedef struct packed {
    logic [23:0]        h;
    logic [N-1:0][55:0] s;
  } pkt_t;
  typedef logic [31:0][PW-1:0] slot_t;

  logic               clk_pixel = 1'b0;
  logic               reset = 1'b1;
  logic               island = 1'b0;
  logic               pkt_valid = 1'b0;
  logic [23:0]        pkt_header = '0;
  logic [N-1:0][55:0] pkt_sub = '0;
  logic               pkt_ready;
  logic [PW-1:0]      packet_data;
  logic [4:0]         counter;
  logic               slot_start, null_slot, slot_aborted;
  logic [1:0]         fifo_level;
  logic               inj_s;
`ifdef PACKET_ECC_INJECT_EN
  logic               ecc_inject = 1'b0;
  assign inj_s = ecc_inject;
`else
  assign inj_s = 1'b0;
`endif

  packet_stream_assembler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (island),
    .pkt_valid          (pkt_valid),
    .pkt_ready          (pkt_ready),
    .pkt_header         (pkt_header),
    .pkt_sub            (pkt_sub),
`ifdef PACKET_ECC_INJECT_EN
    .ecc_inject         (ecc_inject),
`endif
    .packet_data        (packet_data),
    .counter            (counter),
    .slot_start         (slot_start),
    .null_slot          (null_slot),
    .slot_aborted       (slot_aborted),
    .fifo_level         (fifo_level)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: parity of a whole bit string, then serialise the 32-bit header
  // codeword and the 64-bit subpacket codewords across the slot.
  function automatic logic [7:0] ecc_of(input logic [63:0] bits, input int n);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < n; i++)
      e = (e >> 1) ^ ((e[0] ^ bits[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  function automatic slot_t build_slot(input pkt_t p, input logic inj);
    slot_t       w;
    logic [31:0] hb;
    logic [63:0] sb;
    w  = '0;
    hb = {ecc_of({40'b0, p.h}, 24) ^ {7'b0, inj}, p.h};
    for (int c = 0; c < 32; c++) w[c][0] = hb[c];
    for (int k = 0; k < N; k++) begin
      sb = {ecc_of({8'b0, p.s[k]}, 56) ^ {7'b0, inj}, p.s[k]};
      for (int c = 0; c < 32; c++) begin
        w[c][k+1]   = sb[2*c];
        w[c][k+1+N] = sb[2*c+1];
      end
    end
    return w;
  endfunction

  // Scoreboard: every accepted packet is an expected future slot.
  pkt_t exp_q[$];
  always @(posedge clk_pixel)
    if (!reset && pkt_valid && pkt_ready) exp_q.push_back({pkt_header, pkt_sub});

  // Monitor
  int         m_cnt = 0;
  logic       abort_pend = 1'b0;
  logic       cur_null = 1'b0;
  slot_t      cur_w = '0;
  logic [7:0] last_hdr_par = '0;

  always @(negedge clk_pixel) begin
    if (reset) begin
      exp_q.delete();
      m_cnt      = 0;
      abort_pend = 1'b0;
    end else begin
      chk("fifo_level", fifo_level, exp_q.size());
      chk("pkt_ready", pkt_ready, exp_q.size() < DEPTH);
      chk("counter", counter, m_cnt);
      chk("slot_aborted", slot_aborted, abort_pend);
      if (island) begin
        if (m_cnt == 0) begin
          cur_null = (exp_q.size() == 0);
          if (cur_null) cur_w = '0;
          else          cur_w = build_slot(exp_q[0], inj_s);
        end
        chk("slot_start", slot_start, m_cnt == 0);
        chk("null_slot", null_slot, cur_null);
        chk("packet_data", packet_data, cur_w[m_cnt]);
        if (m_cnt >= 24) last_hdr_par[m_cnt-24] = packet_data[0];
        if (m_cnt == 31 && !cur_null) void'(exp_q.pop_front());
      end else begin
        chk("slot_start_idle", slot_start, 1'b0);
      end
      abort_pend = !island && (m_cnt != 0);
      m_cnt      = island ? (m_cnt + 1) % 32 : 0;
    end
  end

  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic push_pkt(input pkt_t p);
    logic acc;
    acc        = 1'b0;
    pkt_header = p.h;
    pkt_sub    = p.s;
    pkt_valid  = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = pkt_ready;
      tick();
    end
    pkt_valid = 1'b0;
    chk("push_accepted", acc, 1'b1);
  endtask

  task automatic run_island(input int n);
    island = 1'b1;
    repeat (n) tick();
    island = 1'b0;
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t        p;
    logic [31:0] r;
    logic [63:0] t;
    r   = $urandom;
    p.h = r[23:0];
    for (int k = 0; k < N; k++) begin
      t      = {$urandom, $urandom};
      p.s[k] = t[55:0];
    end
    return p;
  endfunction

  logic drv_done = 1'b0;

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_counter", counter, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", pkt_ready, 1);
    chk("rst_null", null_slot, 0);
    chk("rst_abort", slot_aborted, 0);

    // Null slot with an empty FIFO
    run_island(32);
    tick();

    // Single-bit header: known header parity
    p = '0; p.h = 24'h000001;
    push_pkt(p);
    chk("level_one", fifo_level, 1);
    run_island(32);
    tick();
    chk("hdr_parity_4A", last_hdr_par, 8'h4A);
    chk("level_after_pop", fifo_level, 0);

    // Back-pressure and back-to-back slots
    push_pkt(rand_pkt());
    push_pkt(rand_pkt());
    chk("ready_full", pkt_ready, 0);
    fork
      push_pkt(rand_pkt());
      run_island(128);
    join
    tick();

    // Abort at counter 17, then retransmit
    push_pkt(rand_pkt());
    island = 1'b1;
    for (int i = 0; i < 64 && counter != 5'd17; i++) tick();
    chk("reach_17", counter, 17);
    island = 1'b0;
    tick();
    chk("abort_pulse", slot_aborted, 1);
    chk("abort_level", fifo_level, 1);
    tick();
    run_island(32);
    tick();

    // Reset in the middle of a slot discards the queue
    push_pkt(rand_pkt());
    push_pkt(rand_pkt());
    island = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    island = 1'b0;
    tick();
    chk("midrst_level", fifo_level, 0);
    chk("midrst_counter", counter, 0);
    run_island(32);
    tick();

`ifdef PACKET_ECC_INJECT_EN
    ecc_inject = 1'b1;
    p = '0; p.h = 24'h000001;
    push_pkt(p);
    run_island(32);
    tick();
    ecc_inject = 1'b0;
    chk("hdr_parity_4B", last_hdr_par, 8'h4B);
`endif

    // Randomised traffic with occasional mid-slot drops
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          push_pkt(rand_pkt());
          repeat ($urandom_range(0, 20)) tick();
        end
        drv_done = 1'b1;
      end
      begin
        int cyc;
        int len;
        cyc = 0;
        while ((!drv_done || exp_q.size() != 0) && cyc < 30000) begin
          len = 32 * $urandom_range(1, 3);
          if ($urandom_range(0, 7) == 0) len = $urandom_range(1, 95);
          run_island(len);
          cyc += len;
          repeat ($urandom_range(0, 3)) begin
            tick();
            cyc++;
          end
        end
        chk("random_drain", exp_q.size(), 0);
      end
    join
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
